// File: rtl/qsys_test_ws2812_tx.sv
// WS2812 single-wire LED transmitter fed by an Avalon-ST pixel stream.
// Each 24-bit RGB pixel is sent GRB, MSB first; a latch gap follows every NUM_LEDS pixels.
module qsys_test_ws2812_tx #(
  parameter int unsigned T0H      = 20,
  parameter int unsigned T1H      = 40,
  parameter int unsigned TBIT     = 63,
  parameter int unsigned TRST     = 2500,
  parameter int unsigned NUM_LEDS = 1
) (
  input  logic        rsi_MRST_reset,
  input  logic        csi_MCLK_clk,
  input  logic [23:0] asi_LEDS_data,
  input  logic        asi_LEDS_valid,
  output logic        asi_LEDS_ready,
  output logic        coe_LED_dout,
  output logic        coe_LED_busy
);

  localparam int unsigned TW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int unsigned LW = (TRST > 1) ? $clog2(TRST) : 1;

  localparam logic [TW-1:0] TBIT_LAST = TW'(TBIT - 1);
  localparam logic [TW-1:0] T0H_W     = TW'(T0H);
  localparam logic [TW-1:0] T1H_W     = TW'(T1H);
  localparam logic [LW-1:0] TRST_LAST = LW'(TRST - 1);
  localparam logic [7:0]    NLED_W    = 8'(NUM_LEDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t        state_q;
  logic [23:0]   shift_q;
  logic [4:0]    bit_cnt_q;
  logic [TW-1:0] tick_q;
  logic [7:0]    pix_cnt_q;
  logic [LW-1:0] lat_q;
  logic          dout_q;
  logic          busy_q;

  logic [TW-1:0] tick_d;
  logic [TW-1:0] thi_cur;
  logic [TW-1:0] thi_nxt;
  logic [TW-1:0] thi_new;
  logic [7:0]    pix_cnt_d;

  // dout is registered, so it is computed from the tick/bit the line will show next cycle.
  always_comb begin
    tick_d    = tick_q + 1'b1;
    thi_cur   = shift_q[23] ? T1H_W : T0H_W;
    thi_nxt   = shift_q[22] ? T1H_W : T0H_W;
    thi_new   = asi_LEDS_data[15] ? T1H_W : T0H_W;
    pix_cnt_d = pix_cnt_q + 1'b1;
  end

  assign asi_LEDS_ready = (state_q == S_IDLE);
  assign coe_LED_dout   = dout_q;
  assign coe_LED_busy   = busy_q;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      pix_cnt_q <= '0;
      lat_q     <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_q <= 1'b0;
          if (asi_LEDS_valid) begin
            shift_q   <= {asi_LEDS_data[15:8], asi_LEDS_data[23:16], asi_LEDS_data[7:0]};
            bit_cnt_q <= '0;
            tick_q    <= '0;
            state_q   <= S_SEND;
            busy_q    <= 1'b1;
            dout_q    <= (thi_new != '0);
          end
        end
        S_SEND: begin
          if (tick_q == TBIT_LAST) begin
            tick_q <= '0;
            shift_q <= {shift_q[22:0], 1'b0};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q <= '0;
              pix_cnt_q <= pix_cnt_d;
              dout_q    <= 1'b0;
              if (pix_cnt_d == NLED_W) begin
                state_q <= S_LATCH;
                lat_q   <= '0;
                busy_q  <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              dout_q    <= (thi_nxt != '0);
            end
          end else begin
            tick_q <= tick_d;
            dout_q <= (tick_d < thi_cur);
          end
        end
        S_LATCH: begin
          dout_q <= 1'b0;
          if (lat_q == TRST_LAST) begin
            lat_q     <= '0;
            pix_cnt_q <= '0;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          shift_q   <= '0;
          bit_cnt_q <= '0;
          tick_q    <= '0;
          pix_cnt_q <= '0;
          lat_q     <= '0;
          dout_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/qsys_test_ws2812_tx.md
QSYS_TEST_WS2812_TX -- requirements
Module: qsys_test_ws2812_tx

Interface
REQ-001 The block SHALL have parameter T0H, default 20, giving the '0' bit high time in clocks (400 ns at 50 MHz).
REQ-002 The block SHALL have parameter T1H, default 40, giving the '1' bit high time in clocks (800 ns).
REQ-003 The block SHALL have parameter TBIT, default 63, giving the total bit period in clocks; T0H < T1H < TBIT holds by construction.
REQ-004 The block SHALL have parameter TRST, default 2500, giving the latch low time in clocks (50 us).
REQ-005 The block SHALL have parameter NUM_LEDS, default 1, giving the pixels per frame before a latch; range 1..255.
REQ-006 rsi_MRST_reset  in  1  asynchronous, active-high reset.
REQ-007 csi_MCLK_clk  in  1  clock; all logic is on the rising edge.
REQ-008 asi_LEDS_data  in  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 asi_LEDS_valid  in  1  Avalon-ST valid.
REQ-010 asi_LEDS_ready  out  1  Avalon-ST ready.
REQ-011 coe_LED_dout  out  1  WS2812 serial line, registered.
REQ-012 coe_LED_busy  out  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement states IDLE, SEND and LATCH.
REQ-014 asi_LEDS_ready SHALL be 1 only in IDLE; it is decoded combinationally from the state.
REQ-015 A pixel SHALL transfer only on a cycle with asi_LEDS_valid=1 and asi_LEDS_ready=1; data at any other time is ignored.
REQ-016 On transfer, the block SHALL load the 24-bit shift register with {G,R,B}, i.e. {data[15:8],data[23:16],data[7:0]}, clear bit_cnt and tick, and enter SEND.
REQ-017 In SEND, tick SHALL count 0..TBIT-1 per bit; coe_LED_dout=1 for tick < THI, else 0, where THI=T1H when the shift MSB is 1 and T0H otherwise.
REQ-018 coe_LED_dout SHALL rise in the cycle after the transfer cycle, giving an acceptance-to-first-edge latency of 1 clock.
REQ-019 At tick=TBIT-1, the shift register SHALL shift left by 1, bit_cnt SHALL increment and tick SHALL clear; bits are sent MSB first, 24 bits per pixel.
REQ-020 When bit 23 completes (tick=TBIT-1, bit_cnt=23), pix_cnt SHALL increment.
REQ-021 If the new pix_cnt equals NUM_LEDS, the state SHALL go to LATCH; otherwise it SHALL go to IDLE.
REQ-022 In LATCH, coe_LED_dout SHALL be held 0 for exactly TRST clocks; the block SHALL then clear pix_cnt and return to IDLE.
REQ-023 In IDLE, coe_LED_dout SHALL be 0.
REQ-024 The pixel bit period SHALL be exactly TBIT clocks; a pixel SHALL occupy exactly 24*TBIT clocks of SEND.
REQ-025 Back-to-back pixels: with valid held high, the IDLE dwell between pixels SHALL be exactly 1 clock.
REQ-026 Counter widths: tick SHALL be at least clog2(TBIT) bits and the latch counter at least clog2(TRST) bits; no counter may wrap inside a period.
REQ-027 If the state register holds an illegal encoding, the block SHALL return to IDLE with all counters cleared and dout=0.

Reset
REQ-028 Reset assertion SHALL immediately force: state=IDLE, shift=0, bit_cnt=0, tick=0, pix_cnt=0, latch counter=0, coe_LED_dout=0, coe_LED_busy=0.
REQ-029 Reset asserted mid-SEND or mid-LATCH SHALL abort the frame, and dout SHALL fall low asynchronously.
REQ-030 After reset release, asi_LEDS_ready SHALL be 1 on the first clock.
REQ-031 After reset release, the next accepted pixel SHALL start a new frame with pix_cnt=0.

Verification
REQ-032 Reset: assert reset mid-bit while dout=1 -> dout=0, busy=0 and ready=1 within the reset cycle, with no clock edge required.
REQ-033 Single pixel 0xFF0000, NUM_LEDS=1 -> G=0x00, then R=0xFF, then B=0x00; check:
- the first 8 bits are 20-clock highs;
- the next 8 bits are 40-clock highs;
- the last 8 bits are 20-clock highs;
- every bit period is 63 clocks;
- dout is then low for 2500 clocks, and ready=1 on the next cycle.
REQ-034 Pattern 0x00AA55 -> transmitted GRB sequence is 0xAA,0x00,0x55; the high-time sequence decodes bit-exact to 0xAA0055.
REQ-035 Handshake: valid low for 100 clocks in IDLE -> dout stays 0 and busy stays 0; valid pulsed while busy -> the pixel is not consumed and ready stays 0.
REQ-036 NUM_LEDS=3 with valid held high -> three pixels, each separated by 1 IDLE clock; one latch after pixel 3; the 4th pixel is accepted exactly TRST+1 clocks after pixel 3 ends.
REQ-037 Reset during LATCH at count 1000 -> after release, the next pixel transmits immediately with no residual latch wait.
